ram_bist: RTL

Built-in self-test engine that acts as the initiator on the team's RAM port: it drives the write/read command signals and consumes `read_data`/`read_valid`. It runs a 4-phase march test over every address, compares read-back data against the expected background pattern, and reports pass/fail with error count and first-failure location. It sits between a top-level test controller and any RAM that implements the responder side of the port, with arbitrary fixed or variable read latency.

---
 rtl/ram_bist.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ram_bist.sv
// March-test BIST initiator for the RAM port: P0/P1 backgrounds over four phases with error capture.
// Optional read-response watchdog is enabled by defining RAM_BIST_TIMEOUT_EN.
module ram_bist #(
  parameter int D_WIDTH    = 32,
  parameter int A_WIDTH    = 5,
  parameter int RD_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [A_WIDTH+1:0] err_count,
  output logic [A_WIDTH-1:0] fail_addr,
  output logic [1:0]         fail_phase,
  output logic [D_WIDTH-1:0] write_data,
  output logic [A_WIDTH-1:0] write_addr,
  output logic               write_en,
  output logic [A_WIDTH-1:0] read_addr,
  output logic               read_en,
  input  logic [D_WIDTH-1:0] read_data,
  input  logic               read_valid
);

  // state   | meaning
  // S_IDLE  | waiting for start after reset
  // S_WRITE | phase 0, one P0 write per cycle, ascending
  // S_RD    | issue one read
  // S_WAIT  | wait for read_valid (or timeout), then compare
  // S_WR    | write complement pattern, then advance address/phase
  // S_DONE  | results held until next start
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_RD, S_WAIT, S_WR, S_DONE} state_t;

  function automatic logic [D_WIDTH-1:0] pat_p0();
    logic [D_WIDTH-1:0] p;
    for (int i = 0; i < D_WIDTH; i++) p[i] = ((i % 2) == 0);
    return p;
  endfunction

  localparam logic [D_WIDTH-1:0] P0    = pat_p0();
  localparam logic [D_WIDTH-1:0] P1    = ~P0;
  localparam logic [A_WIDTH-1:0] A_MAX = '1;

  state_t             state, state_nxt;
  logic [A_WIDTH-1:0] addr;
  logic [1:0]         phase;
  logic [D_WIDTH-1:0] expected;
  logic               timed_out;
  logic               resp;
  logic               fault;

`ifdef RAM_BIST_TIMEOUT_EN
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  logic [TW-1:0] tmr;

  // Loaded alongside read_en so WAIT lasts at most RD_TIMEOUT cycles.
  always_ff @(posedge clk) begin
    if (rst)                                tmr <= '0;
    else if (state == S_RD)                 tmr <= TW'(RD_TIMEOUT - 1);
    else if (state == S_WAIT && tmr != '0)  tmr <= tmr - 1'b1;
  end

  assign timed_out = (state == S_WAIT) && !read_valid && (tmr == '0);
`else
  logic unused_rd_timeout;
  assign unused_rd_timeout = ^RD_TIMEOUT;
  assign timed_out = 1'b0;
`endif

  assign expected   = (phase == 2'd2) ? P1 : P0;
  assign resp       = (state == S_WAIT) && (read_valid || timed_out);
  assign fault      = resp && (timed_out || (read_data != expected));
  assign write_addr = addr;
  assign read_addr  = addr;
  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign done       = (state == S_DONE);
  assign pass       = done && (err_count == '0);

  always_comb begin
    state_nxt  = state;
    write_en   = 1'b0;
    read_en    = 1'b0;
    write_data = '0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_WRITE;
      S_WRITE: begin
        write_en   = 1'b1;
        write_data = P0;
        if (addr == A_MAX) state_nxt = S_RD;
      end
      S_RD: begin
        read_en    = 1'b1;
        write_data = expected;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        write_data = expected;
        if (resp) begin
          if (phase != 2'd3)     state_nxt = S_WR;
          else if (addr == '0)   state_nxt = S_DONE;
          else                   state_nxt = S_RD;
        end
      end
      S_WR: begin
        write_en   = 1'b1;
        write_data = ~expected;
        state_nxt  = S_RD;
      end
      S_DONE:  if (start) state_nxt = S_WRITE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr       <= '0;
      phase      <= '0;
      err_count  <= '0;
      fail_addr  <= '0;
      fail_phase <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_DONE: if (start) begin
          addr       <= '0;
          phase      <= '0;
          err_count  <= '0;
          fail_addr  <= '0;
          fail_phase <= '0;
        end
        S_WRITE: begin
          if (addr == A_MAX) begin
            addr  <= '0;
            phase <= 2'd1;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        S_WAIT: if (resp) begin
          if (fault) begin
            err_count <= err_count + 1'b1;
            if (err_count == '0) begin
              fail_addr  <= addr;
              fail_phase <= phase;
            end
          end
          // Phase 3 has no write step, so it advances straight from the compare.
          if (phase == 2'd3 && addr != '0) addr <= addr - 1'b1;
        end
        S_WR: begin
          if (phase == 2'd1) begin
            if (addr == A_MAX) phase <= 2'd2;
            else               addr  <= addr + 1'b1;
          end else begin
            if (addr == '0) begin
              phase <= 2'd3;
              addr  <= A_MAX;
            end else begin
              addr <= addr - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
